// File: rtl/expr_eval_if.sv
// Token/result bundle for the expression evaluator: the producer drives tokens,
// the evaluator drives the handshake and the result strobe.
interface expr_eval_if #(
  parameter int DATA_W = 10
);
  logic              en;
  logic [6:0]        variable;
  logic              req;
  logic              valid;
  logic [DATA_W-1:0] answer;
  logic              err;

  modport master (output en, output variable, input req, input valid, input answer, input err);
  modport slave  (input en, input variable, output req, output valid, output answer, output err);
endinterface

// File: rtl/expr_eval.sv
// Infix expression evaluator: ASCII tokens in, one result per '=' out.
// Operand and operator stacks with precedence-driven reduction, one reduction per cycle.
module expr_eval #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  expr_eval_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {INIT, ACCEPT, RED_OP, RED_PAR, RED_ALL, DONE} state_t;
  typedef enum logic [1:0] {OP_LPAR = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_MUL = 2'd3} op_t;
  typedef enum logic [2:0] {TK_DIGIT, TK_OP, TK_LPAR, TK_RPAR, TK_EQ, TK_BAD} tok_t;

  state_t            state_q;
  logic [DATA_W-1:0] opnd_q [DEPTH];
  op_t               oper_q [DEPTH];
  logic [CW-1:0]     ocnt_q;
  logic [CW-1:0]     pcnt_q;
  op_t               lat_q;
  logic              err_flag_q;
  logic              req_q;
  logic              valid_q;
  logic              err_q;
  logic [DATA_W-1:0] answer_q;

  logic [IW-1:0]     otop_s, osec_s, onew_s, ptop_s, pnew_s;
  op_t               top_op_s;
  logic              top_is_op_s, reduce_s, ofull_s, pfull_s;
  logic [DATA_W-1:0] a_s, b_s, red_res_s, digit_s;
  tok_t              tok_kind_s;
  op_t               tok_op_s;

  function automatic logic [1:0] prec(input op_t op);
    return (op == OP_MUL) ? 2'd2 : 2'd1;
  endfunction

  // Stack-top views, reduction result and token decode.
  always_comb begin
    otop_s      = IW'(ocnt_q - CW'(1));
    osec_s      = IW'(ocnt_q - CW'(2));
    onew_s      = IW'(ocnt_q);
    ptop_s      = IW'(pcnt_q - CW'(1));
    pnew_s      = IW'(pcnt_q);
    ofull_s     = (ocnt_q == CW'(DEPTH));
    pfull_s     = (pcnt_q == CW'(DEPTH));
    top_op_s    = oper_q[ptop_s];
    b_s         = opnd_q[otop_s];
    a_s         = opnd_q[osec_s];
    top_is_op_s = (pcnt_q != CW'(0)) && (top_op_s != OP_LPAR);
    digit_s     = DATA_W'(bus.variable[3:0]);

    case (top_op_s)
      OP_ADD:  red_res_s = a_s + b_s;
      OP_SUB:  red_res_s = a_s - b_s;
      OP_MUL:  red_res_s = a_s * b_s;
      default: red_res_s = {DATA_W{1'b0}};
    endcase

    case (state_q)
      RED_OP:  reduce_s = top_is_op_s && (prec(top_op_s) >= prec(lat_q));
      RED_PAR: reduce_s = top_is_op_s;
      RED_ALL: reduce_s = top_is_op_s;
      default: reduce_s = 1'b0;
    endcase

    tok_op_s = OP_ADD;
    case (bus.variable) inside
      [7'h30:7'h39]: tok_kind_s = TK_DIGIT;
      7'h2B:         tok_kind_s = TK_OP;
      7'h2D: begin
        tok_kind_s = TK_OP;
        tok_op_s   = OP_SUB;
      end
      7'h2A: begin
        tok_kind_s = TK_OP;
        tok_op_s   = OP_MUL;
      end
      7'h28:         tok_kind_s = TK_LPAR;
      7'h29:         tok_kind_s = TK_RPAR;
      7'h3D:         tok_kind_s = TK_EQ;
      default:       tok_kind_s = TK_BAD;
    endcase
  end

  // Control FSM, stacks and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INIT;
      ocnt_q     <= CW'(0);
      pcnt_q     <= CW'(0);
      lat_q      <= OP_ADD;
      err_flag_q <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      answer_q   <= {DATA_W{1'b0}};
    end else begin
      valid_q <= 1'b0;
      // With fewer than two operands the pops are skipped and a zero stands in.
      if (reduce_s) begin
        pcnt_q <= pcnt_q - CW'(1);
        if (ocnt_q >= CW'(2)) begin
          opnd_q[osec_s] <= red_res_s;
          ocnt_q         <= ocnt_q - CW'(1);
        end else begin
          err_flag_q <= 1'b1;
          if (!ofull_s) begin
            opnd_q[onew_s] <= {DATA_W{1'b0}};
            ocnt_q         <= ocnt_q + CW'(1);
          end
        end
      end

      case (state_q)
        INIT: begin
          state_q <= ACCEPT;
          req_q   <= 1'b0;
        end
        ACCEPT: begin
          req_q <= 1'b1;
          if (bus.en && req_q) begin
            case (tok_kind_s)
              TK_DIGIT: begin
                if (ofull_s) begin
                  err_flag_q <= 1'b1;
                end else begin
                  opnd_q[onew_s] <= digit_s;
                  ocnt_q         <= ocnt_q + CW'(1);
                end
              end
              TK_LPAR: begin
                if (pfull_s) begin
                  err_flag_q <= 1'b1;
                end else begin
                  oper_q[pnew_s] <= OP_LPAR;
                  pcnt_q         <= pcnt_q + CW'(1);
                end
              end
              TK_OP: begin
                lat_q   <= tok_op_s;
                state_q <= RED_OP;
                req_q   <= 1'b0;
              end
              TK_RPAR: begin
                state_q <= RED_PAR;
                req_q   <= 1'b0;
              end
              TK_EQ: begin
                state_q <= RED_ALL;
                req_q   <= 1'b0;
              end
              default: err_flag_q <= 1'b1;
            endcase
          end
        end
        RED_OP: begin
          if (!reduce_s) begin
            if (pfull_s) begin
              err_flag_q <= 1'b1;
            end else begin
              oper_q[pnew_s] <= lat_q;
              pcnt_q         <= pcnt_q + CW'(1);
            end
            state_q <= ACCEPT;
            req_q   <= 1'b1;
          end
        end
        RED_PAR: begin
          if (!reduce_s) begin
            if (pcnt_q == CW'(0)) begin
              err_flag_q <= 1'b1;
            end else begin
              pcnt_q <= pcnt_q - CW'(1);
            end
            state_q <= ACCEPT;
            req_q   <= 1'b1;
          end
        end
        RED_ALL: begin
          // Not reducing with a non-empty stack means an unmatched '(' is on top.
          if (!reduce_s) begin
            if (pcnt_q != CW'(0)) begin
              pcnt_q     <= pcnt_q - CW'(1);
              err_flag_q <= 1'b1;
            end else begin
              state_q <= DONE;
              valid_q <= 1'b1;
              if (!err_flag_q && (ocnt_q == CW'(1))) begin
                answer_q <= opnd_q[0];
                err_q    <= 1'b0;
              end else begin
                answer_q <= {DATA_W{1'b0}};
                err_q    <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q    <= ACCEPT;
          req_q      <= 1'b1;
          ocnt_q     <= CW'(0);
          pcnt_q     <= CW'(0);
          err_flag_q <= 1'b0;
        end
        default: begin
          state_q <= INIT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req    = req_q;
  assign bus.valid  = valid_q;
  assign bus.answer = answer_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_expr_eval.sv
// Directed-vector bench for expr_eval: a queue-based shunting-yard model predicts each
// result, a negedge monitor checks every valid pulse and the answer hold in between.
module tb_expr_eval;
  localparam int DW   = 10;
  localparam int DP   = 4;
  localparam int MASK = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  expr_eval_if #(.DATA_W(DW)) bus ();
  expr_eval #(.DATA_W(DW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_expr = 0;
  int exp_ans_q[$];
  bit exp_err_q[$];
  int last_ans = 0;
  bit hold_armed = 1'b0;

  int  m_vals[$];
  byte m_ops[$];
  bit  m_err;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic void m_push_val(input int v);
    if (m_vals.size() >= DP) m_err = 1'b1;
    else m_vals.push_back(v);
  endfunction

  function automatic void m_push_op(input byte c);
    if (m_ops.size() >= DP) m_err = 1'b1;
    else m_ops.push_back(c);
  endfunction

  function automatic int m_prec(input byte c);
    return (c == 8'h2A) ? 2 : 1;
  endfunction

  function automatic void m_reduce();
    byte op;
    int a, b, r;
    op = m_ops.pop_back();
    if (m_vals.size() < 2) begin
      m_err = 1'b1;
      m_push_val(0);
    end else begin
      b = m_vals.pop_back();
      a = m_vals.pop_back();
      case (op)
        8'h2B:   r = a + b;
        8'h2D:   r = a - b;
        default: r = a * b;
      endcase
      m_push_val(r & MASK);
    end
  endfunction

  task automatic model(input string s, output int ans, output bit e);
    byte c;
    m_vals.delete();
    m_ops.delete();
    m_err = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) m_push_val(int'(c) - 48);
      else if (c == 8'h28) m_push_op(c);
      else if (c == 8'h2B || c == 8'h2D || c == 8'h2A) begin
        while (m_ops.size() > 0 && m_ops[$] != 8'h28 && m_prec(m_ops[$]) >= m_prec(c)) m_reduce();
        m_push_op(c);
      end else if (c == 8'h29) begin
        while (m_ops.size() > 0 && m_ops[$] != 8'h28) m_reduce();
        if (m_ops.size() == 0) m_err = 1'b1;
        else void'(m_ops.pop_back());
      end else if (c == 8'h3D) begin
        while (m_ops.size() > 0) begin
          if (m_ops[$] == 8'h28) begin
            m_err = 1'b1;
            void'(m_ops.pop_back());
          end else m_reduce();
        end
      end else m_err = 1'b1;
    end
    e   = m_err || (m_vals.size() != 1);
    ans = e ? 0 : m_vals[0];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      n_valid++;
      if (exp_ans_q.size() == 0) begin
        check(1'b0, "unexpected_valid", 1, 0);
      end else begin
        check(bus.answer == exp_ans_q[0], "answer", int'(bus.answer), exp_ans_q[0]);
        check(bus.err == exp_err_q[0], "err", int'(bus.err), int'(exp_err_q[0]));
        void'(exp_ans_q.pop_front());
        void'(exp_err_q.pop_front());
      end
      last_ans   = int'(bus.answer);
      hold_armed = 1'b1;
    end else if (hold_armed) begin
      check(int'(bus.answer) == last_ans, "answer_hold", int'(bus.answer), last_ans);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_tok(input logic [6:0] t);
    int k = 0;
    @(negedge clk);
    while (!bus.req && k < 100) begin
      bus.en = 1'b0;
      @(negedge clk);
      k++;
    end
    if (k >= 100) check(1'b0, "req_timeout", 0, 1);
    bus.en       = 1'b1;
    bus.variable = t;
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic poke_busy(input logic [6:0] t);
    @(negedge clk);
    check(bus.req == 1'b0, "busy_req", int'(bus.req), 0);
    bus.en       = 1'b1;
    bus.variable = t;
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic run_expr(input string s, input int lit_ans, input bit lit_err,
                          input int exp_lat, input int poke_after);
    int  ma, cyc;
    bit  me;
    byte c;
    model(s, ma, me);
    check(ma == lit_ans, {"model_ans ", s}, ma, lit_ans);
    check(me == lit_err, {"model_err ", s}, int'(me), int'(lit_err));
    exp_ans_q.push_back(lit_ans);
    exp_err_q.push_back(lit_err);
    n_expr++;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_tok(c[6:0]);
      if (i == poke_after) poke_busy(7'h39);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.valid !== 1'b1 && cyc < 100);
    if (cyc >= 100) check(1'b0, {"valid_timeout ", s}, 0, 1);
    if (exp_lat != 0) check(cyc == exp_lat, "valid_latency", cyc, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.variable = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    check(bus.req == 1'b0, "rst_req", int'(bus.req), 0);
    check(bus.valid == 1'b0, "rst_valid", int'(bus.valid), 0);
    check(bus.answer == '0, "rst_answer", int'(bus.answer), 0);
    check(bus.err == 1'b0, "rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check(bus.req == 1'b0, "init_req", int'(bus.req), 0);

    run_expr("3+4*2=", 11, 1'b0, 4, -1);
    run_expr("(1+2)*(3+4)=", 21, 1'b0, 0, -1);
    run_expr("8-2-3=", 3, 1'b0, 0, -1);
    run_expr("2-9=", 1017, 1'b0, 0, -1);
    run_expr("9*9*9*9=", 417, 1'b0, 0, -1);
    run_expr("1+(2+(3+(4+(5+6))))=", 0, 1'b1, 0, -1);
    run_expr("5=", 5, 1'b0, 0, -1);
    run_expr("1+2)=", 0, 1'b1, 0, -1);
    run_expr("7=", 7, 1'b0, 0, -1);
    run_expr("+=", 0, 1'b1, 0, -1);
    run_expr("7=", 7, 1'b0, 0, -1);
    run_expr("1A=", 0, 1'b1, 0, -1);
    run_expr("7=", 7, 1'b0, 0, -1);

    // Reset mid-expression: partial "1+2" must vanish without a valid pulse.
    send_tok(7'h31);
    send_tok(7'h2B);
    send_tok(7'h32);
    @(negedge clk);
    hold_armed = 1'b0;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    check(bus.req == 1'b0, "midrst_req", int'(bus.req), 0);
    check(bus.valid == 1'b0, "midrst_valid", int'(bus.valid), 0);
    check(bus.answer == '0, "midrst_answer", int'(bus.answer), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check(bus.req == 1'b0, "release_req", int'(bus.req), 0);
    run_expr("7=", 7, 1'b0, 0, -1);

    // A '9' strobed during the RED_OP bubble after '+' must be ignored.
    run_expr("3+4=", 7, 1'b0, 0, 1);
    run_expr("6*(5-7)=", 1012, 1'b0, 0, -1);

    repeat (4) @(negedge clk);
    check(n_valid == n_expr, "valid_count", n_valid, n_expr);
    check(exp_ans_q.size() == 0, "pending_results", exp_ans_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 SHALL have parameter DATA_W, default 10: operand/result width; all arithmetic is modulo 2^DATA_W.
REQ-002 SHALL have parameter DEPTH, default 16: entries in each of the operand stack and the operator stack.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-low (asserted when rst==0 at a rising clk edge).
REQ-005 SHALL have port en  input  1  token strobe; the token is accepted only when en==1 and req==1 at a rising edge.
REQ-006 SHALL have port variable  input  7  token, ASCII: '0'-'9' (0x30-0x39), '+' 0x2B, '-' 0x2D, '*' 0x2A, '(' 0x28, ')' 0x29, '=' 0x3D.
REQ-007 SHALL have port req  output  1  the block can accept a token this cycle.
REQ-008 SHALL have port valid  output  1  one-cycle result strobe.
REQ-009 SHALL have port answer  output  DATA_W  result; meaningful only while valid==1.
REQ-010 SHALL have port err  output  1  error qualifier for answer; meaningful only while valid==1.

Function
REQ-011 SHALL evaluate one infix expression per '=' token: single-digit operands; '*' higher precedence than '+'/'-'; left-associative; parentheses nest.
REQ-012 SHALL use states INIT, ACCEPT, RED_OP, RED_PAR, RED_ALL, DONE; req==1 only in ACCEPT.
REQ-013 INIT SHALL go to ACCEPT on the next edge.
REQ-014 In ACCEPT, an accepted digit SHALL be zero-extended to DATA_W and pushed onto the operand stack; state stays ACCEPT (back-to-back tokens allowed).
REQ-015 In ACCEPT, an accepted '(' SHALL be pushed onto the operator stack; state stays ACCEPT.
REQ-016 An accepted '+', '-' or '*' SHALL be latched and the state SHALL go to RED_OP.
REQ-017 In RED_OP, while the operator-stack top is an operator of precedence >= the latched one: one reduction per cycle. Otherwise: push the latched operator and go to ACCEPT (minimum one cycle with req==0).
REQ-018 An accepted ')' SHALL go to RED_PAR.
REQ-019 In RED_PAR: reduce one per cycle until the top is '('. Then pop it and go to ACCEPT. An empty operator stack SHALL set the error flag and return to ACCEPT.
REQ-020 An accepted '=' SHALL go to RED_ALL.
REQ-021 In RED_ALL: reduce one per cycle while the operator stack is non-empty (a '(' on top SHALL set the error flag and be popped). When the stack is empty, go to DONE.
REQ-022 A reduction SHALL, in one cycle:
- pop operator op;
- pop b (top), then a;
- push (a op b) truncated to DATA_W bits.
'-' wraps modulo 2^DATA_W; '*' keeps the low DATA_W bits.
REQ-023 DONE SHALL drive valid=1 for exactly one cycle, then return to ACCEPT with both stacks empty and the error flag cleared.
- If the error flag is clear and the operand count is exactly 1: answer = that operand, err = 0.
- Otherwise: answer = 0, err = 1.
REQ-024 The error flag SHALL be sticky within an expression. It is set by any of:
- push to a full stack (the push is dropped);
- a reduction with fewer than two operands (pop skipped, 0 pushed);
- an unlisted token code (token discarded).
REQ-025 While errored, the block SHALL still consume tokens normally until '='.
REQ-026 en while req==0 SHALL be ignored with no state change.
REQ-027 answer SHALL hold its value from the valid cycle until the next valid.
REQ-028 Stack occupancy counters SHALL be ceil(log2(DEPTH+1)) bits and SHALL never wrap.

Reset
REQ-029 With rst==0 at an edge, the block SHALL go to INIT, empty both stacks, and clear the error flag; req=0, valid=0, answer=0, err=0.
REQ-030 Reset SHALL take precedence over en and over any in-progress reduction.
REQ-031 After reset is released (rst==1 at the next edge), the block SHALL pass through INIT, so req rises no earlier than the second edge after release.
REQ-032 Reset mid-expression SHALL discard all partial state with no valid pulse.

Verification
REQ-033 Tokens "3+4*2=" -> exactly one valid, answer=11, err=0; in RED_ALL, two reduction cycles plus one empty-check cycle precede DONE.
REQ-034 Tokens "(1+2)*(3+4)=" -> answer=21, err=0; tokens "8-2-3=" -> answer=3 (left-associative).
REQ-035 DATA_W=10: "2-9=" -> answer=1017, err=0. "9*9*9*9=" -> answer=6561 mod 1024=417.
REQ-036 DEPTH=4: "1+(2+(3+(4+(5+6))))=" -> valid with answer=0, err=1. The following "5=" -> answer=5, err=0.
REQ-037 Error cases, each followed by the same recovery check (a following "7=" -> answer=7, err=0):
- "1+2)=" -> err=1;
- "+=" -> err=1;
- token 0x41 in "1A=" -> err=1.
REQ-038 Reset and handshake:
- send "1+2", hold rst=0 one cycle -> req=0, no valid. Then "7=" -> answer=7, err=0.
- en pulsed while req==0 -> no effect on the result.
